// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and the saturating conjugate helper for the
// twiddle coefficient sequencer.
package fft_pkg;

  localparam int NBITS  = 11;
  localparam int N      = 32;
  localparam int NSTAGE = 7;
  localparam int WPS    = 2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] LAST = 2'd2;

  localparam int CONJ_W = 32;

  // Two's complement negate of an nbits-wide value held in the low bits of v.
  // The most negative code has no positive twin and clamps to the largest one.
  function automatic logic [CONJ_W-1:0] conj_sat(input logic [CONJ_W-1:0] v,
                                                 input int nbits);
    logic [CONJ_W-1:0] mask;
    logic [CONJ_W-1:0] minv;
    mask = (CONJ_W'(1) << nbits) - CONJ_W'(1);
    minv = CONJ_W'(1) << (nbits - 1);
    if ((v & mask) == minv) begin
      return minv - CONJ_W'(1);
    end
    return (~v + CONJ_W'(1)) & mask;
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Synchronous single-port coefficient ROM; one full N-lane word per read.
module twiddle_rom #(
  parameter int unsigned         DW        = 704,
  parameter int unsigned         DEPTH     = 14,
  parameter int unsigned         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter string               INIT_FILE = "coeff.mem",
  parameter logic [DW*DEPTH-1:0] INIT_VEC  = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] r_mem [DEPTH];

  initial begin
    for (int a = 0; a < int'(DEPTH); a++) begin
      r_mem[a] = INIT_VEC[a*DW +: DW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (en) begin
      dout <= r_mem[addr];
    end
  end

endmodule

// File: rtl/twiddle_coeff_sequencer.sv
// Streams every stage's twiddle vectors from one ROM with valid/ready handshake
// and an optional saturating conjugate (IFFT) view of the imaginary parts.
module twiddle_coeff_sequencer #(
  parameter int unsigned NBITS     = fft_pkg::NBITS,
  parameter int unsigned N         = fft_pkg::N,
  parameter int unsigned NSTAGE    = fft_pkg::NSTAGE,
  parameter int unsigned WPS       = fft_pkg::WPS,
  parameter string       INIT_FILE = "coeff.mem",
  parameter logic [NSTAGE*WPS*2*NBITS*N-1:0] INIT_VEC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      inv_mode,
  output logic                      busy,
  output logic                      done,
  output logic                      coeff_valid,
  input  logic                      coeff_ready,
  output logic [2*NBITS*N-1:0]      coeff_data,
  output logic [$clog2(NSTAGE)-1:0] stage_idx,
  output logic                      last_word
);

  import fft_pkg::*;

  localparam int unsigned DEPTH = NSTAGE * WPS;
  localparam int unsigned DW    = 2 * NBITS * N;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW    = $clog2(NSTAGE);
  localparam int unsigned CW    = (WPS > 1) ? $clog2(WPS) : 1;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_inv;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_wcnt;
  logic [SW-1:0] r_scnt;
  logic [SW-1:0] r_stage;
  logic          r_last;
  logic          r_valid;
  logic          w_rd_en;
  logic          w_accept;
  logic          w_addr_last;
  logic [DW-1:0] w_rom_dout;

  // A new word is fetched only when the output register is empty or draining.
  assign w_rd_en     = (r_state == RUN) && (!r_valid || coeff_ready);
  assign w_accept    = r_valid && coeff_ready;
  assign w_addr_last = (r_addr == AW'(DEPTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_rd_en && w_addr_last) w_state_nxt = LAST;
      LAST:    if (w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_inv   <= 1'b0;
      r_addr  <= '0;
      r_wcnt  <= '0;
      r_scnt  <= '0;
      r_stage <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_inv <= inv_mode;
      end
      if (w_rd_en) begin
        r_stage <= r_scnt;
        r_last  <= w_addr_last;
        if (w_addr_last) begin
          r_addr <= '0;
          r_wcnt <= '0;
          r_scnt <= '0;
        end else begin
          r_addr <= r_addr + AW'(1);
          if (r_wcnt == CW'(WPS - 1)) begin
            r_wcnt <= '0;
            r_scnt <= r_scnt + SW'(1);
          end else begin
            r_wcnt <= r_wcnt + CW'(1);
          end
        end
      end
      if (w_rd_en) begin
        r_valid <= 1'b1;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  twiddle_rom #(
    .DW        (DW),
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE),
    .INIT_VEC  (INIT_VEC)
  ) u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (w_rd_en),
    .addr (r_addr),
    .dout (w_rom_dout)
  );

  for (genvar k = 0; k < int'(N); k++) begin : g_lane
    localparam int unsigned HI = (N - k) * 2 * NBITS - 1;
    logic [NBITS-1:0] w_re;
    logic [NBITS-1:0] w_im;
    logic [NBITS-1:0] w_im_conj;
    assign w_re      = w_rom_dout[HI -: NBITS];
    assign w_im      = w_rom_dout[HI-NBITS -: NBITS];
    assign w_im_conj = NBITS'(conj_sat(CONJ_W'(w_im), int'(NBITS)));
    assign coeff_data[HI -: 2*NBITS] = {w_re, r_inv ? w_im_conj : w_im};
  end

  assign busy        = (r_state != IDLE);
  assign done        = (r_state == LAST) && w_accept;
  assign coeff_valid = r_valid;
  assign stage_idx   = r_stage;
  assign last_word   = r_last;

endmodule
